load_store_unit: RTL and testbench

- Initiator side of the byte-addressed data-memory interface; sits between the execute/memory stage and data memory.
- Accepts one load/store per valid/ready handshake and drives the memory's rd_en/wr_en/addr/mem_acc_mode/rdata2 ports. Memory is big-endian: the byte at addr is the MSB, it reads asynchronously and it writes on posedge.
- Splits misaligned accesses into sequential byte beats, performs sign/zero extension itself, bounds-checks addresses and returns the result through a resp_valid/resp_ready handshake.

---
 rtl/lsu_pkg.sv | 40 ++++
 rtl/lsu_load_extend.sv | 21 ++
 rtl/load_store_unit.sv | 140 ++++++++++++++
 tb/tb_load_store_unit.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: memory access modes, RISC-V load/store
// funct3 values, controller states and request-size decode helpers.
package lsu_pkg;

    localparam logic [2:0] MODE_BYTE       = 3'b000;
    localparam logic [2:0] MODE_HALFWORD   = 3'b001;
    localparam logic [2:0] MODE_WORD       = 3'b010;
    localparam logic [2:0] MODE_BYTE_U     = 3'b011;
    localparam logic [2:0] MODE_HALFWORD_U = 3'b100;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } lsu_state_t;

    // Access size in bytes; illegal encodings report 1 so address math stays sane.
    function automatic logic [2:0] f3_size(input logic [2:0] f3);
        case (f3)
            F3_H, F3_HU: return 3'd2;
            F3_W:        return 3'd4;
            default:     return 3'd1;
        endcase
    endfunction

    function automatic logic f3_legal(input logic [2:0] f3, input logic we);
        case (f3)
            F3_B, F3_H, F3_W: return 1'b1;
            F3_BU, F3_HU:     return !we;
            default:          return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_load_extend.sv
// Sign/zero extension of raw load data according to the load's funct3.
module lsu_load_extend
    import lsu_pkg::*;
(
    input  logic [31:0] i_raw,
    input  logic [2:0]  i_funct3,
    output logic [31:0] o_ext
);

    always_comb begin
        o_ext = i_raw;
        case (i_funct3)
            F3_B:    o_ext = {{24{i_raw[7]}}, i_raw[7:0]};
            F3_BU:   o_ext = {24'd0, i_raw[7:0]};
            F3_H:    o_ext = {{16{i_raw[15]}}, i_raw[15:0]};
            F3_HU:   o_ext = {16'd0, i_raw[15:0]};
            default: o_ext = i_raw;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store initiator for a big-endian byte-addressed data memory: bounds and
// legality checks, optional byte-beat splitting of misaligned accesses, load extension.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int MEM_BYTES        = 100,
    parameter bit SPLIT_MISALIGNED = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_fault,
    output logic        rd_en,
    output logic        wr_en,
    output logic [31:0] addr,
    output logic [2:0]  mem_acc_mode,
    output logic [31:0] rdata2,
    input  logic [31:0] rdata
);

    lsu_state_t  r_state, w_next;
    logic [1:0]  r_beat, w_beat_next;
    logic [1:0]  r_last;
    logic        r_we, r_split, r_fault;
    logic [2:0]  r_funct3;
    logic [31:0] r_addr, r_wdata, r_acc;

    logic [2:0]  w_size;
    logic [1:0]  w_mask;
    logic        w_misal, w_oob, w_fault, w_accept, w_in_access;
    logic [32:0] w_end;
    logic [1:0]  w_sel;
    logic [2:0]  w_aligned_mode;
    logic [31:0] w_ext;

    // Request decode, evaluated against the incoming request in IDLE
    assign w_size   = f3_size(req_funct3);
    assign w_mask   = w_size[1:0] - 2'd1;
    assign w_misal  = |(req_addr[1:0] & w_mask);
    assign w_end    = {1'b0, req_addr} + {30'd0, w_size} - 33'd1;
    assign w_oob    = w_end >= 33'(MEM_BYTES);
    assign w_fault  = !f3_legal(req_funct3, req_we) || w_oob || (w_misal && !SPLIT_MISALIGNED);
    assign w_accept = req_valid && (r_state == IDLE);

    always_comb begin
        w_next      = r_state;
        w_beat_next = r_beat;
        case (r_state)
            IDLE: begin
                if (req_valid) begin
                    w_next      = w_fault ? RESP : ACCESS;
                    w_beat_next = 2'd0;
                end
            end
            ACCESS: begin
                if (r_beat == r_last) w_next = RESP;
                else                  w_beat_next = r_beat + 2'd1;
            end
            RESP: begin
                if (resp_ready) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_beat  <= 2'd0;
        end else begin
            r_state <= w_next;
            r_beat  <= w_beat_next;
        end
    end

    // Request capture and load accumulation; split loads assemble bytes MSB-first
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_we     <= req_we;
            r_funct3 <= req_funct3;
            r_addr   <= req_addr;
            r_wdata  <= req_wdata;
            r_split  <= w_misal;
            r_last   <= w_misal ? w_mask : 2'd0;
            r_fault  <= w_fault;
            r_acc    <= 32'd0;
        end else if (r_state == ACCESS && !r_we) begin
            r_acc <= r_split ? {r_acc[23:0], rdata[7:0]} : rdata;
        end
    end

    // Memory port drive, zero outside ACCESS
    assign w_in_access = (r_state == ACCESS);
    assign w_sel       = r_last - r_beat;

    always_comb begin
        case (r_funct3)
            F3_B, F3_BU: w_aligned_mode = r_we ? MODE_BYTE : MODE_BYTE_U;
            F3_H, F3_HU: w_aligned_mode = r_we ? MODE_HALFWORD : MODE_HALFWORD_U;
            default:     w_aligned_mode = MODE_WORD;
        endcase
    end

    always_comb begin
        rd_en        = 1'b0;
        wr_en        = 1'b0;
        addr         = 32'd0;
        mem_acc_mode = 3'd0;
        rdata2       = 32'd0;
        if (w_in_access) begin
            rd_en        = !r_we;
            wr_en        = r_we;
            addr         = r_addr + {30'd0, r_beat};
            mem_acc_mode = r_split ? (r_we ? MODE_BYTE : MODE_BYTE_U) : w_aligned_mode;
            if (r_we)
                rdata2 = r_split ? {24'd0, r_wdata[{w_sel, 3'b000} +: 8]} : r_wdata;
        end
    end

    lsu_load_extend u_extend (
        .i_raw    (r_acc),
        .i_funct3 (r_funct3),
        .o_ext    (w_ext)
    );

    // Response side
    assign req_ready  = (r_state == IDLE);
    assign resp_valid = (r_state == RESP);
    assign resp_fault = (r_state == RESP) && r_fault;
    assign resp_rdata = ((r_state == RESP) && !r_fault && !r_we) ? w_ext : 32'd0;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: big-endian memory model plus a byte-array reference
// of memory contents, directed scenarios followed by randomized requests.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'd0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] resp_rdata;
    logic        resp_fault;
    logic        rd_en, wr_en;
    logic [31:0] addr;
    logic [2:0]  mem_acc_mode;
    logic [31:0] rdata2;
    logic [31:0] rdata;
    logic        tb_init = 1'b1;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    load_store_unit #(.MEM_BYTES(100), .SPLIT_MISALIGNED(1'b1)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_fault(resp_fault),
        .rd_en(rd_en), .wr_en(wr_en), .addr(addr), .mem_acc_mode(mem_acc_mode),
        .rdata2(rdata2), .rdata(rdata)
    );

    // Data memory: big-endian, asynchronous read, posedge write
    logic [7:0]  mem [0:99];
    logic [31:0] a1, a2, a3;
    logic [7:0]  b0, b1, b2, b3;
    assign a1 = addr + 32'd1;
    assign a2 = addr + 32'd2;
    assign a3 = addr + 32'd3;
    assign b0 = (addr < 32'd100) ? mem[addr[6:0]] : 8'h00;
    assign b1 = (a1 < 32'd100) ? mem[a1[6:0]] : 8'h00;
    assign b2 = (a2 < 32'd100) ? mem[a2[6:0]] : 8'h00;
    assign b3 = (a3 < 32'd100) ? mem[a3[6:0]] : 8'h00;

    always_comb begin
        rdata = 32'd0;
        case (mem_acc_mode)
            3'b000:  rdata = {{24{b0[7]}}, b0};
            3'b011:  rdata = {24'd0, b0};
            3'b001:  rdata = {{16{b0[7]}}, b0, b1};
            3'b100:  rdata = {16'd0, b0, b1};
            3'b010:  rdata = {b0, b1, b2, b3};
            default: rdata = 32'd0;
        endcase
    end

    always @(posedge clk) begin
        if (tb_init) begin
            for (int i = 0; i < 100; i++) mem[i] <= 8'(i * 7 + 3);
        end else if (wr_en) begin
            case (mem_acc_mode)
                3'b000, 3'b011: begin
                    if (addr < 32'd100) mem[addr[6:0]] <= rdata2[7:0];
                end
                3'b001, 3'b100: begin
                    if (addr < 32'd100) mem[addr[6:0]] <= rdata2[15:8];
                    if (a1 < 32'd100)   mem[a1[6:0]]   <= rdata2[7:0];
                end
                3'b010: begin
                    if (addr < 32'd100) mem[addr[6:0]] <= rdata2[31:24];
                    if (a1 < 32'd100)   mem[a1[6:0]]   <= rdata2[23:16];
                    if (a2 < 32'd100)   mem[a2[6:0]]   <= rdata2[15:8];
                    if (a3 < 32'd100)   mem[a3[6:0]]   <= rdata2[7:0];
                end
                default: ;
            endcase
        end
    end

    // Reference memory contents
    logic [7:0] ref_mem [0:99];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int size_of(input logic [2:0] f3);
        if (f3 == 3'b001 || f3 == 3'b101) return 2;
        if (f3 == 3'b010) return 4;
        return 1;
    endfunction

    // One request through accept, beats and response; entered and left just after a negedge.
    task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input int hold, output logic [31:0] got);
        int         s, nb;
        bit         legal, fault, misal;
        longint     val;
        logic [31:0] exp_rd, exp_addr, exp_wd;
        logic [2:0]  exp_mode;
        logic [31:0] held;
        s     = size_of(f3);
        legal = (f3 == 3'b000 || f3 == 3'b001 || f3 == 3'b010 ||
                 (!we && (f3 == 3'b100 || f3 == 3'b101)));
        fault = !legal || (({32'd0, a} + 64'(s) - 64'd1) >= 64'd100);
        misal = (a % s) != 0;
        nb    = fault ? 0 : (misal ? s : 1);
        exp_rd = 32'd0;
        if (!fault && !we) begin
            val = 0;
            for (int i = 0; i < s; i++) val = val * 256 + longint'(ref_mem[a + i]);
            if (f3 == 3'b000 && val >= 128)   val -= 256;
            if (f3 == 3'b001 && val >= 32768) val -= 65536;
            exp_rd = 32'(val);
        end

        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
        chk("req_ready_idle", {31'd0, req_ready}, 32'd1);
        @(negedge clk);
        req_valid = 1'b0;

        for (int k = 0; k < nb; k++) begin
            if (!misal) begin
                exp_addr = a;
                exp_mode = we ? ((s == 1) ? 3'b000 : (s == 2) ? 3'b001 : 3'b010)
                              : ((s == 1) ? 3'b011 : (s == 2) ? 3'b100 : 3'b010);
                exp_wd   = wd;
            end else begin
                exp_addr = a + 32'(k);
                exp_mode = we ? 3'b000 : 3'b011;
                exp_wd   = (wd >> (8 * (s - 1 - k))) & 32'hFF;
            end
            chk("beat_rd_en", {31'd0, rd_en}, {31'd0, !we});
            chk("beat_wr_en", {31'd0, wr_en}, {31'd0, we});
            chk("beat_addr", addr, exp_addr);
            chk("beat_mode", {29'd0, mem_acc_mode}, {29'd0, exp_mode});
            if (we) chk("beat_rdata2", rdata2, exp_wd);
            chk("beat_no_resp", {31'd0, resp_valid}, 32'd0);
            @(negedge clk);
        end

        chk("resp_valid", {31'd0, resp_valid}, 32'd1);
        chk("resp_fault", {31'd0, resp_fault}, {31'd0, fault});
        chk("resp_rdata", resp_rdata, exp_rd);
        chk("resp_no_mem", {30'd0, rd_en, wr_en}, 32'd0);
        chk("resp_req_ready", {31'd0, req_ready}, 32'd0);
        got  = resp_rdata;
        held = resp_rdata;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk("hold_valid", {31'd0, resp_valid}, 32'd1);
            chk("hold_rdata", resp_rdata, held);
            chk("hold_fault", {31'd0, resp_fault}, {31'd0, fault});
            chk("hold_req_ready", {31'd0, req_ready}, 32'd0);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        chk("after_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("after_req_ready", {31'd0, req_ready}, 32'd1);

        if (we && !fault)
            for (int i = 0; i < s; i++) ref_mem[a + i] = 8'((wd >> (8 * (s - 1 - i))) & 32'hFF);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] got, ra, rw;
        logic [2:0]  rf;
        logic        rwe;
        for (int i = 0; i < 100; i++) ref_mem[i] = 8'(i * 7 + 3);

        @(negedge clk);
        @(negedge clk);
        chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'd0);
        chk("rst_resp_fault", {31'd0, resp_fault}, 32'd0);
        chk("rst_en", {30'd0, rd_en, wr_en}, 32'd0);
        chk("rst_addr", addr, 32'd0);
        chk("rst_mode", {29'd0, mem_acc_mode}, 32'd0);
        chk("rst_rdata2", rdata2, 32'd0);
        tb_init = 1'b0;
        rst     = 1'b0;
        @(negedge clk);

        do_req(1'b1, 3'b010, 32'd8, 32'hDEADBEEF, 0, got);
        do_req(1'b0, 3'b010, 32'd8, 32'd0, 0, got);
        chk("lw8_const", got, 32'hDEADBEEF);
        do_req(1'b0, 3'b000, 32'd8, 32'd0, 0, got);
        chk("lb8_const", got, 32'hFFFFFFDE);
        do_req(1'b0, 3'b100, 32'd8, 32'd0, 0, got);
        chk("lbu8_const", got, 32'h000000DE);
        do_req(1'b0, 3'b001, 32'd10, 32'd0, 0, got);
        chk("lh10_const", got, 32'hFFFFBEEF);
        do_req(1'b0, 3'b101, 32'd10, 32'd0, 0, got);
        chk("lhu10_const", got, 32'h0000BEEF);

        do_req(1'b1, 3'b010, 32'd5, 32'h11223344, 0, got);
        do_req(1'b0, 3'b010, 32'd5, 32'd0, 0, got);
        chk("lw5_split_const", got, 32'h11223344);
        do_req(1'b0, 3'b001, 32'd7, 32'd0, 0, got);
        chk("lh7_split_const", got, 32'h00003344);

        do_req(1'b0, 3'b010, 32'd98, 32'd0, 0, got);
        do_req(1'b0, 3'b011, 32'd4, 32'd0, 0, got);
        do_req(1'b1, 3'b100, 32'd4, 32'h5A, 0, got);
        do_req(1'b0, 3'b010, 32'hFFFFFFFE, 32'd0, 0, got);
        do_req(1'b0, 3'b000, 32'd99, 32'd0, 0, got);

        do_req(1'b0, 3'b010, 32'd8, 32'd0, 3, got);

        // Reset during the third beat of a split store at 5
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010;
        req_addr = 32'd5; req_wdata = 32'hAABBCCDD;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rstmid_beat2_addr", addr, 32'd7);
        rst = 1'b1;
        #1;
        chk("rstmid_wr_en", {31'd0, wr_en}, 32'd0);
        chk("rstmid_addr", addr, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        chk("rstmid_req_ready", {31'd0, req_ready}, 32'd1);
        chk("rstmid_no_resp", {31'd0, resp_valid}, 32'd0);
        chk("rstmid_mem5", {24'd0, mem[5]}, 32'hAA);
        chk("rstmid_mem6", {24'd0, mem[6]}, 32'hBB);
        chk("rstmid_mem7", {24'd0, mem[7]}, {24'd0, ref_mem[7]});
        chk("rstmid_mem8", {24'd0, mem[8]}, {24'd0, ref_mem[8]});
        ref_mem[5] = 8'hAA;
        ref_mem[6] = 8'hBB;
        @(negedge clk);
        chk("rstmid_still_idle", {31'd0, resp_valid}, 32'd0);

        for (int n = 0; n < 120; n++) begin
            rwe = 1'($urandom_range(0, 1));
            rf  = 3'($urandom_range(0, 7));
            ra  = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 103));
            rw  = $urandom;
            do_req(rwe, rf, ra, rw, int'($urandom_range(0, 2)), got);
        end

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
